// File: rtl/rtc_bus_pkg.sv
// ---------------------------------------------------------------------------
// rtc_bus_pkg
// Shared definitions for the RTC bus responder:
//   - register addresses on the multiplexed RTC bus
//   - field selectors used between the bus decode and the time counter
//   - reset values and BCD field limits
//   - BCD helpers: days_in_month() and bcd_inc()
// ---------------------------------------------------------------------------
package rtc_bus_pkg;

  // Time field selectors; the low three address bits of 0x21..0x26 map
  // directly onto these, so the bus decode can pass addr[2:0] through.
  localparam logic [2:0] FLD_SEC   = 3'd1;
  localparam logic [2:0] FLD_MIN   = 3'd2;
  localparam logic [2:0] FLD_HOUR  = 3'd3;
  localparam logic [2:0] FLD_DAY   = 3'd4;
  localparam logic [2:0] FLD_MONTH = 3'd5;
  localparam logic [2:0] FLD_YEAR  = 3'd6;

  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_SEC   = {5'b00100, FLD_SEC};
  localparam logic [7:0] ADDR_MIN   = {5'b00100, FLD_MIN};
  localparam logic [7:0] ADDR_HOUR  = {5'b00100, FLD_HOUR};
  localparam logic [7:0] ADDR_DAY   = {5'b00100, FLD_DAY};
  localparam logic [7:0] ADDR_MONTH = {5'b00100, FLD_MONTH};
  localparam logic [7:0] ADDR_YEAR  = {5'b00100, FLD_YEAR};

  // CTRL bit positions
  localparam int CTRL_IE_BIT   = 0;
  localparam int CTRL_PEND_BIT = 7;

  // Reset values
  localparam logic [7:0] RST_ADDR  = 8'h00;
  localparam logic [7:0] RST_SEC   = 8'h00;
  localparam logic [7:0] RST_MIN   = 8'h00;
  localparam logic [7:0] RST_HOUR  = 8'h00;
  localparam logic [7:0] RST_DAY   = 8'h01;
  localparam logic [7:0] RST_MONTH = 8'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;

  // BCD field limits (day maximum comes from days_in_month)
  localparam logic [7:0] SEC_MIN   = 8'h00;
  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] MIN_MIN   = 8'h00;
  localparam logic [7:0] MIN_MAX   = 8'h59;
  localparam logic [7:0] HOUR_MIN  = 8'h00;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] DAY_MIN   = 8'h01;
  localparam logic [7:0] MONTH_MIN = 8'h01;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam logic [7:0] YEAR_MIN  = 8'h00;
  localparam logic [7:0] YEAR_MAX  = 8'h99;

  typedef struct packed {
    logic       carry;
    logic [7:0] val;
  } bcd_inc_t;

  // Last day of the month, in BCD. A BCD year is divisible by 4 when
  // (2*tens + ones) mod 4 == 0, since 10 == 2 (mod 4); only tens[0] and
  // ones[1:0] matter for that.
  function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                               input logic [7:0] year);
    logic [1:0] m4;
    m4 = {year[4], 1'b0} + year[1:0];
    case (month)
      8'h02:                      days_in_month = (m4 == 2'd0) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: days_in_month = 8'h30;
      default:                    days_in_month = 8'h31;
    endcase
  endfunction

  // One BCD step. Anything at or beyond the maximum (including junk BCD
  // written by software) wraps to the minimum and carries out.
  function automatic bcd_inc_t bcd_inc(input logic [7:0] v,
                                       input logic [7:0] vmin,
                                       input logic [7:0] vmax);
    bcd_inc_t r;
    if (v >= vmax) begin
      r.carry = 1'b1;
      r.val   = vmin;
    end else begin
      r.carry = 1'b0;
      if (v[3:0] >= 4'd9) r.val = {v[7:4] + 4'd1, 4'h0};
      else                r.val = v + 8'd1;
    end
    return r;
  endfunction

  function automatic logic is_time_addr(input logic [7:0] a);
    return (a >= ADDR_SEC) && (a <= ADDR_YEAR);
  endfunction

endpackage

// File: rtl/rtc_bus_responder_counter.sv
// ---------------------------------------------------------------------------
// bcd_time_counter
// Six BCD time/date registers with per-field bus load and a tick-driven
// ripple increment.
//   clk, reset      : clock, synchronous active-high reset
//   i_tick          : 1-cycle tick from the prescaler
//   i_wr_en         : load one field this cycle
//   i_wr_fld        : field selector (FLD_SEC..FLD_YEAR)
//   i_wr_data       : value to load
//   o_sec..o_year   : current field values
// A load and a tick in the same cycle: the load wins and the whole ripple
// is replayed one cycle later on the freshly loaded values.
// ---------------------------------------------------------------------------
module bcd_time_counter
  import rtc_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_fld,
  input  logic [7:0] i_wr_data,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic [7:0] o_hour,
  output logic [7:0] o_day,
  output logic [7:0] o_month,
  output logic [7:0] o_year
);

  logic [7:0] r_sec, r_min, r_hour, r_day, r_month, r_year;
  logic       r_tick_defer;

  bcd_inc_t   w_sec_i, w_min_i, w_hour_i, w_day_i, w_month_i, w_year_i;
  logic       w_tick_any;
  logic       w_min_en, w_hour_en, w_day_en, w_month_en, w_year_en;

  assign w_tick_any = i_tick | r_tick_defer;

  always_comb begin
    w_sec_i   = bcd_inc(r_sec,   SEC_MIN,   SEC_MAX);
    w_min_i   = bcd_inc(r_min,   MIN_MIN,   MIN_MAX);
    w_hour_i  = bcd_inc(r_hour,  HOUR_MIN,  HOUR_MAX);
    w_day_i   = bcd_inc(r_day,   DAY_MIN,   days_in_month(r_month, r_year));
    w_month_i = bcd_inc(r_month, MONTH_MIN, MONTH_MAX);
    w_year_i  = bcd_inc(r_year,  YEAR_MIN,  YEAR_MAX);
  end

  // Carry chain: a field advances only if every lower field wrapped.
  assign w_min_en   = w_sec_i.carry;
  assign w_hour_en  = w_min_en   & w_min_i.carry;
  assign w_day_en   = w_hour_en  & w_hour_i.carry;
  assign w_month_en = w_day_en   & w_day_i.carry;
  assign w_year_en  = w_month_en & w_month_i.carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec        <= RST_SEC;
      r_min        <= RST_MIN;
      r_hour       <= RST_HOUR;
      r_day        <= RST_DAY;
      r_month      <= RST_MONTH;
      r_year       <= RST_YEAR;
      r_tick_defer <= 1'b0;
    end else begin
      r_tick_defer <= w_tick_any & i_wr_en;
      if (i_wr_en) begin
        case (i_wr_fld)
          FLD_SEC:   r_sec   <= i_wr_data;
          FLD_MIN:   r_min   <= i_wr_data;
          FLD_HOUR:  r_hour  <= i_wr_data;
          FLD_DAY:   r_day   <= i_wr_data;
          FLD_MONTH: r_month <= i_wr_data;
          FLD_YEAR:  r_year  <= i_wr_data;
          default: ;
        endcase
      end else if (w_tick_any) begin
        r_sec <= w_sec_i.val;
        if (w_min_en)   r_min   <= w_min_i.val;
        if (w_hour_en)  r_hour  <= w_hour_i.val;
        if (w_day_en)   r_day   <= w_day_i.val;
        if (w_month_en) r_month <= w_month_i.val;
        if (w_year_en)  r_year  <= w_year_i.val;
      end
    end
  end

  assign o_sec   = r_sec;
  assign o_min   = r_min;
  assign o_hour  = r_hour;
  assign o_day   = r_day;
  assign o_month = r_month;
  assign o_year  = r_year;

endmodule

// File: rtl/rtc_bus_responder.sv
// ---------------------------------------------------------------------------
// rtc_bus_responder
// Stand-in for the external RTC chip on the multiplexed address/data bus.
//   clk, reset : system clock, synchronous active-high reset
//   cs_n       : chip select (async to clk)
//   ad_n       : 0 = address phase, 1 = data phase
//   rd_n, wr_n : read / write strobes, active-low
//   dat_in     : bus value seen at the pad
//   dat_out    : read data (registered)
//   dat_oe     : pad drive enable
//   irq_n      : tick interrupt, active-low level
// All bus pins go through one aligned 2-FF synchronizer; strobe edges are
// detected on the synchronized copies, so a write commits 3 clk after wr_n
// rises at the pin and dat_oe follows rd_n with 3 clk of latency.
// ---------------------------------------------------------------------------
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_DIV = CLK_HZ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       ad_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] dat_in,
  output logic [7:0] dat_out,
  output logic       dat_oe,
  output logic       irq_n
);

  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  // Idle bus: all strobes high, data don't-care.
  localparam logic [11:0]    SYNC_IDLE = {4'b1111, 8'h00};

  // ---------------- synchronizer + edge detect ----------------
  logic [11:0] r_sync1, r_sync2;
  logic        r_rd_prev, r_wr_prev;
  logic        w_cs_n, w_ad_n, w_rd_n, w_wr_n;
  logic [7:0]  w_dat;
  logic        w_rd_rise, w_wr_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= SYNC_IDLE;
      r_sync2   <= SYNC_IDLE;
      r_rd_prev <= 1'b1;
      r_wr_prev <= 1'b1;
    end else begin
      r_sync1   <= {cs_n, ad_n, rd_n, wr_n, dat_in};
      r_sync2   <= r_sync1;
      r_rd_prev <= w_rd_n;
      r_wr_prev <= w_wr_n;
    end
  end

  assign {w_cs_n, w_ad_n, w_rd_n, w_wr_n, w_dat} = r_sync2;
  assign w_rd_rise = w_rd_n & ~r_rd_prev;
  assign w_wr_rise = w_wr_n & ~r_wr_prev;

  // ---------------- bus decode ----------------
  // Cycles with both strobes low are treated as bus errors and ignored.
  logic [7:0] r_addr;
  logic       w_addr_wr, w_data_wr, w_rd_act, w_ctrl_rd_done;
  logic       w_time_wr, w_ctrl_wr;

  assign w_addr_wr      = ~w_cs_n & ~w_ad_n & w_wr_rise & w_rd_n;
  assign w_data_wr      = ~w_cs_n &  w_ad_n & w_wr_rise & w_rd_n;
  assign w_rd_act       = ~w_cs_n &  w_ad_n & ~w_rd_n   & w_wr_n;
  assign w_ctrl_rd_done = ~w_cs_n &  w_ad_n & w_rd_rise & w_wr_n
                        & (r_addr == ADDR_CTRL);
  assign w_time_wr      = w_data_wr & is_time_addr(r_addr);
  assign w_ctrl_wr      = w_data_wr & (r_addr == ADDR_CTRL);

  always_ff @(posedge clk) begin
    if (reset)          r_addr <= RST_ADDR;
    else if (w_addr_wr) r_addr <= w_dat;
  end

  // ---------------- prescaler ----------------
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (reset)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // ---------------- CTRL ----------------
  logic r_ie, r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ie      <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ie <= w_dat[CTRL_IE_BIT];
      // A tick beats a simultaneous read-clear so no event is lost.
      if (w_tick)              r_pending <= 1'b1;
      else if (w_ctrl_rd_done) r_pending <= 1'b0;
    end
  end

  assign irq_n = ~(r_pending & r_ie);

  // ---------------- time registers ----------------
  logic [7:0] w_sec, w_min, w_hour, w_day, w_month, w_year;

  bcd_time_counter u_time (
    .clk       (clk),
    .reset     (reset),
    .i_tick    (w_tick),
    .i_wr_en   (w_time_wr),
    .i_wr_fld  (r_addr[2:0]),
    .i_wr_data (w_dat),
    .o_sec     (w_sec),
    .o_min     (w_min),
    .o_hour    (w_hour),
    .o_day     (w_day),
    .o_month   (w_month),
    .o_year    (w_year)
  );

  // ---------------- read path ----------------
  logic [7:0] w_rd_mux;
  logic [7:0] r_dat_out;
  logic       r_dat_oe;

  always_comb begin
    w_rd_mux = 8'h00;
    case (r_addr)
      ADDR_CTRL: begin
        w_rd_mux[CTRL_PEND_BIT] = r_pending;
        w_rd_mux[CTRL_IE_BIT]   = r_ie;
      end
      ADDR_SEC:   w_rd_mux = w_sec;
      ADDR_MIN:   w_rd_mux = w_min;
      ADDR_HOUR:  w_rd_mux = w_hour;
      ADDR_DAY:   w_rd_mux = w_day;
      ADDR_MONTH: w_rd_mux = w_month;
      ADDR_YEAR:  w_rd_mux = w_year;
      default:    w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dat_out <= 8'h00;
      r_dat_oe  <= 1'b0;
    end else begin
      r_dat_oe  <= w_rd_act;
      r_dat_out <= w_rd_act ? w_rd_mux : 8'h00;
    end
  end

  assign dat_out = r_dat_out;
  assign dat_oe  = r_dat_oe;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_responder
// Directed bench: bus writes/reads through tasks, expected read results
// queued when the read is launched and popped when the data is sampled.
// A free-running cycle counter tracks the 1 s tick period so stimulus can
// be placed relative to ticks.
// ---------------------------------------------------------------------------
module tb_rtc_bus_responder;

  localparam int TICK_DIV = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1, ad_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0] dat_in = 8'h00;
  logic [7:0] dat_out;
  logic       dat_oe;
  logic       irq_n;

  always #5 clk = ~clk;

  rtc_bus_responder #(.CLK_HZ(1000), .TICK_DIV(TICK_DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_n    (cs_n),
    .ad_n    (ad_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .dat_in  (dat_in),
    .dat_out (dat_out),
    .dat_oe  (dat_oe),
    .irq_n   (irq_n)
  );

  // Tick period tracker: value seen at a negedge is the prescaler phase.
  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= (cyc == TICK_DIV - 1) ? 0 : cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic       oe;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    bit ok = 0;
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      @(negedge clk);
      if (cyc == target) begin ok = 1; break; end
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_cyc timeout target=%0d", target);
    end
  endtask

  // Returns just after a tick has been applied (phase 2 of a new period).
  task automatic wait_tick();
    wait_cyc(2);
  endtask

  task automatic bus_addr(input logic [7:0] a);
    cs_n = 1'b0; ad_n = 1'b0; dat_in = a;
    clks(2); wr_n = 1'b0;
    clks(4); wr_n = 1'b1;
    clks(4); cs_n = 1'b1; ad_n = 1'b1;
    clks(2);
  endtask

  task automatic bus_wdata(input logic [7:0] d);
    cs_n = 1'b0; ad_n = 1'b1; dat_in = d;
    clks(2); wr_n = 1'b0;
    clks(4); wr_n = 1'b1;
    clks(4); cs_n = 1'b1;
    clks(2);
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    bus_addr(a);
    bus_wdata(d);
  endtask

  task automatic reg_read(input string tag, input logic [7:0] a,
                          input logic [7:0] exp, input bit irq_chk);
    exp_t e;
    bus_addr(a);
    cs_n = 1'b0; ad_n = 1'b1;
    sbq.push_back('{tag, 1'b1, exp});
    clks(2); rd_n = 1'b0;
    clks(5);
    e = sbq.pop_front();
    chk({e.tag, ".oe"}, {7'b0, dat_oe}, {7'b0, e.oe});
    chk(e.tag, dat_out, e.data);
    rd_n = 1'b1;
    if (irq_chk) begin
      clks(3);
      chk({tag, ".irq_clr"}, {7'b0, irq_n}, 8'h01);
      clks(1);
    end else begin
      clks(4);
    end
    cs_n = 1'b1;
    clks(2);
  endtask

  task automatic set_time(input logic [7:0] yr, input logic [7:0] mo, input logic [7:0] dy,
                          input logic [7:0] hr, input logic [7:0] mi, input logic [7:0] se);
    reg_write(8'h26, yr);
    reg_write(8'h25, mo);
    reg_write(8'h24, dy);
    reg_write(8'h23, hr);
    reg_write(8'h22, mi);
    reg_write(8'h21, se);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    clks(4);
    reset = 1'b0;
    clks(1);
    chk("rst.dat_oe",  {7'b0, dat_oe}, 8'h00);
    chk("rst.irq_n",   {7'b0, irq_n},  8'h01);
    chk("rst.dat_out", dat_out,        8'h00);

    // Full rollover: 23:59:59 31/12/99 -> 00:00:00 01/01/00
    wait_tick();
    set_time(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    wait_tick();
    reg_read("roll.sec",   8'h21, 8'h00, 0);
    reg_read("roll.min",   8'h22, 8'h00, 0);
    reg_read("roll.hour",  8'h23, 8'h00, 0);
    reg_read("roll.day",   8'h24, 8'h01, 0);
    reg_read("roll.month", 8'h25, 8'h01, 0);
    reg_read("roll.year",  8'h26, 8'h00, 0);

    // Leap year February
    wait_tick();
    set_time(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    wait_tick();
    reg_read("leap.day",   8'h24, 8'h29, 0);
    reg_read("leap.month", 8'h25, 8'h02, 0);
    reg_read("leap.year",  8'h26, 8'h24, 0);
    reg_read("leap.hour",  8'h23, 8'h00, 0);

    // Non-leap February
    wait_tick();
    set_time(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    wait_tick();
    reg_read("nonleap.day",   8'h24, 8'h01, 0);
    reg_read("nonleap.month", 8'h25, 8'h03, 0);
    reg_read("nonleap.year",  8'h26, 8'h23, 0);

    // Unmapped address: reads 0, writes ignored
    wait_tick();
    reg_write(8'h21, 8'h40);
    reg_read("unmap.rd0", 8'h30, 8'h00, 0);
    reg_write(8'h30, 8'h55);
    reg_read("unmap.rd1", 8'h30, 8'h00, 0);
    reg_read("unmap.sec", 8'h21, 8'h40, 0);
    reg_read("unmap.min", 8'h22, 8'h00, 0);
    reg_read("unmap.ctrl", 8'h00, 8'h80, 0);

    // Interrupt: pending from the previous tick, enable, tick, read-clear
    wait_tick();
    reg_read("irq.ctrl0", 8'h00, 8'h80, 0);
    reg_write(8'h00, 8'h01);
    chk("irq.idle", {7'b0, irq_n}, 8'h01);
    wait_tick();
    chk("irq.fire", {7'b0, irq_n}, 8'h00);
    reg_read("irq.ctrl1", 8'h00, 8'h81, 1);

    // Write to sec landing on the tick edge: write wins, tick replayed
    wait_tick();
    reg_write(8'h22, 8'h05);
    reg_write(8'h21, 8'h30);
    bus_addr(8'h21);
    wait_cyc(TICK_DIV - 10);
    cs_n = 1'b0; ad_n = 1'b1; dat_in = 8'h10;
    wait_cyc(TICK_DIV - 8);
    wr_n = 1'b0;
    wait_cyc(TICK_DIV - 3);
    wr_n = 1'b1;
    clks(4); cs_n = 1'b1;
    clks(2);
    reg_read("tickwr.sec", 8'h21, 8'h11, 0);
    reg_read("tickwr.min", 8'h22, 8'h05, 0);

    // Reset in the middle of a read
    wait_tick();
    bus_addr(8'h21);
    cs_n = 1'b0; ad_n = 1'b1;
    sbq.push_back('{"rstrd.sec", 1'b1, 8'h12});
    clks(2); rd_n = 1'b0;
    clks(5);
    e = sbq.pop_front();
    chk({e.tag, ".oe"}, {7'b0, dat_oe}, {7'b0, e.oe});
    chk(e.tag, dat_out, e.data);
    reset = 1'b1;
    clks(1);
    chk("rstrd.oe_drop", {7'b0, dat_oe}, 8'h00);
    cs_n = 1'b1; rd_n = 1'b1; ad_n = 1'b1;
    clks(3);
    reset = 1'b0;
    clks(1);
    chk("rstrd.irq_n",   {7'b0, irq_n}, 8'h01);
    chk("rstrd.dat_out", dat_out,       8'h00);
    reg_read("rstval.ctrl",  8'h00, 8'h00, 0);
    reg_read("rstval.sec",   8'h21, 8'h00, 0);
    reg_read("rstval.min",   8'h22, 8'h00, 0);
    reg_read("rstval.hour",  8'h23, 8'h00, 0);
    reg_read("rstval.day",   8'h24, 8'h01, 0);
    reg_read("rstval.month", 8'h25, 8'h01, 0);
    reg_read("rstval.year",  8'h26, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
